sdrc_wb_traffic_gen: RTL and testbench

Parametrised Wishbone burst traffic generator and checker for the SDRAM controller's Wishbone slave port (`sdrc_top`). After `sdr_init_done`, it writes a programmable number of incrementing bursts with one of four data patterns, then reads them back and compares beat by beat. It reports pass/fail, error count, first failing address and timeout. It replaces hand-written bench write/read sequences and serves as an on-chip memory BIST at any SDRAM width.

---
 rtl/sdrc_tg_pkg.sv | 29 ++
 rtl/sdrc_tg_pattern.sv | 75 +++++++
 rtl/sdrc_wb_traffic_gen.sv | 169 ++++++++++++++++
 tb/tb_sdrc_wb_traffic_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_tg_pkg.sv
// Shared types and constants for the SDRAM Wishbone traffic generator.
//   state_e : control FSM states
//   mode_e  : data pattern selection (cfg_mode encoding)
//   CTI_*   : Wishbone cycle type identifiers used on burst beats
//   LFSR_POLY : 32-bit Galois LFSR feedback polynomial
package sdrc_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WR_BURST,
        ST_WR_GAP,
        ST_RD_BURST,
        ST_RD_GAP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_INC  = 2'b00,
        MODE_LFSR = 2'b01,
        MODE_WALK = 2'b10,
        MODE_ADDR = 2'b11
    } mode_e;

    localparam logic [2:0]  CTI_INCR  = 3'b010;
    localparam logic [2:0]  CTI_EOB   = 3'b111;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/sdrc_tg_pattern.sv
// Data pattern generator. One instance produces write data during the write
// phase and, after a reload from the same seed, the expected read data.
//   sys_clk, RESETN : clock, asynchronous active-low reset
//   load            : reload all pattern state from seed (beat index 0)
//   advance         : step to the next beat (one per acked beat)
//   mode            : pattern select (mode_e encoding)
//   seed            : pattern seed
//   addr            : current beat address, used by address-as-data mode
//   data            : combinational pattern word for the current beat
module sdrc_tg_pattern
    import sdrc_tg_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          sys_clk,
    input  logic          RESETN,
    input  logic          load,
    input  logic          advance,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] seed,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic [DW-1:0] inc_q;
    logic [DW-1:0] walk_q;
    logic [31:0]   lfsr_q;
    logic [31:0]   lfsr_nx;
    logic [31:0]   seed32;
    logic [DW-1:0] lfsr_rep;

    // Galois step: shift right, fold the polynomial in when a one falls out.
    assign lfsr_nx = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
    assign seed32  = 32'(seed);

    // NOTE: every variable written in always_comb gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        lfsr_rep = '0;
        for (int i = 0; i < DW; i++) begin
            lfsr_rep[i] = lfsr_q[i % 32];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of block order.
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            inc_q  <= '0;
            walk_q <= DW'(1);
            lfsr_q <= 32'd1;
        end else if (load) begin
            inc_q  <= seed;
            walk_q <= DW'(1);
            lfsr_q <= (seed32 == 32'd0) ? 32'd1 : seed32;
        end else if (advance) begin
            inc_q  <= inc_q + DW'(1);
            walk_q <= {walk_q[DW-2:0], walk_q[DW-1]};
            lfsr_q <= lfsr_nx;
        end
    end

    always_comb begin
        data = inc_q;
        case (mode_e'(mode))
            MODE_INC:  data = inc_q;
            MODE_LFSR: data = lfsr_rep;
            MODE_WALK: data = walk_q;
            MODE_ADDR: data = DW'(addr);
            default:   data = inc_q;
        endcase
    end

endmodule

// File: rtl/sdrc_wb_traffic_gen.sv
// Wishbone burst traffic generator / checker for the SDRAM controller slave
// port. Writes cfg_num_bursts incrementing bursts of a selectable pattern,
// reads them back and compares each beat.
//   sys_clk, RESETN        : clock, asynchronous active-low reset
//   start                  : launch pulse (ignored while busy)
//   cfg_*                  : run configuration, sampled on the accepted start
//   sdr_init_done          : SDRAM controller ready
//   wb_*                   : Wishbone master interface
//   busy, done, pass, timeout, err_cnt, first_err_addr : run status
module sdrc_wb_traffic_gen
    import sdrc_tg_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int BLW    = 5,
    parameter int TO_CYC = 1024
) (
    input  logic            sys_clk,
    input  logic            RESETN,
    input  logic            start,
    input  logic [AW-1:0]   cfg_base_addr,
    input  logic [BLW-1:0]  cfg_burst_len,
    input  logic [7:0]      cfg_num_bursts,
    input  logic [1:0]      cfg_mode,
    input  logic [DW-1:0]   cfg_seed,
    input  logic            sdr_init_done,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [15:0]     err_cnt,
    output logic [AW-1:0]   first_err_addr
);

    localparam int BYTES = DW / 8;
    localparam int WDW   = $clog2(TO_CYC + 1);

    state_e         state, state_nx;
    logic [AW-1:0]  base_q, addr_q, ferr_q;
    logic [BLW-1:0] last_beat_q, beat_q;
    logic [7:0]     num_bursts_q, burst_q;
    logic [1:0]     mode_q;
    logic [DW-1:0]  seed_q, pat_data;
    logic [WDW-1:0] wd_q;
    logic [15:0]    err_q;
    logic           timeout_q;

    logic in_burst, beat_ack, last_beat, last_burst, wd_expire, accept, phase_load;

    assign in_burst   = (state == ST_WR_BURST) || (state == ST_RD_BURST);
    assign beat_ack   = in_burst && wb_ack_i;
    assign last_beat  = (beat_q == last_beat_q);
    assign last_burst = ((burst_q + 8'd1) == num_bursts_q);
    // An ack in the expiry cycle takes priority over the watchdog.
    assign wd_expire  = in_burst && !wb_ack_i && (wd_q == WDW'(TO_CYC - 1));
    assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    // Pattern and address restart at the head of each phase.
    assign phase_load = ((state == ST_WAIT_INIT) && sdr_init_done) ||
                        ((state == ST_WR_GAP) && (burst_q == num_bursts_q));

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (start) state_nx = (cfg_num_bursts == 8'd0) ? ST_DONE : ST_WAIT_INIT;
            ST_WAIT_INIT: if (sdr_init_done) state_nx = ST_WR_BURST;
            ST_WR_BURST: begin
                if (beat_ack && last_beat) state_nx = ST_WR_GAP;
                else if (wd_expire)        state_nx = ST_DONE;
            end
            ST_WR_GAP:    state_nx = (burst_q == num_bursts_q) ? ST_RD_BURST : ST_WR_BURST;
            ST_RD_BURST: begin
                if (beat_ack && last_beat) state_nx = last_burst ? ST_DONE : ST_RD_GAP;
                else if (wd_expire)        state_nx = ST_DONE;
            end
            ST_RD_GAP:    state_nx = ST_RD_BURST;
            ST_DONE:      if (start) state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            base_q       <= '0;
            addr_q       <= '0;
            ferr_q       <= '0;
            last_beat_q  <= '0;
            beat_q       <= '0;
            num_bursts_q <= '0;
            burst_q      <= '0;
            mode_q       <= '0;
            seed_q       <= '0;
            wd_q         <= '0;
            err_q        <= '0;
            timeout_q    <= 1'b0;
        end else if (accept) begin
            base_q       <= cfg_base_addr;
            last_beat_q  <= (cfg_burst_len == '0) ? '0 : cfg_burst_len - BLW'(1);
            num_bursts_q <= cfg_num_bursts;
            mode_q       <= cfg_mode;
            seed_q       <= cfg_seed;
            err_q        <= '0;
            ferr_q       <= '0;
            timeout_q    <= 1'b0;
        end else if (phase_load) begin
            addr_q  <= base_q;
            beat_q  <= '0;
            burst_q <= '0;
            wd_q    <= '0;
        end else if (beat_ack) begin
            addr_q <= addr_q + AW'(BYTES);
            wd_q   <= '0;
            if (last_beat) begin
                beat_q  <= '0;
                burst_q <= burst_q + 8'd1;
            end else begin
                beat_q <= beat_q + BLW'(1);
            end
            if ((state == ST_RD_BURST) && (wb_dat_i != pat_data)) begin
                if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                if (err_q == 16'd0)    ferr_q <= addr_q;
            end
        end else if (in_burst) begin
            wd_q <= wd_q + WDW'(1);
            if (wd_expire) timeout_q <= 1'b1;
        end
    end

    sdrc_tg_pattern #(.DW(DW), .AW(AW)) u_pattern (
        .sys_clk (sys_clk),
        .RESETN  (RESETN),
        .load    (phase_load),
        .advance (beat_ack),
        .mode    (mode_q),
        .seed    (seed_q),
        .addr    (addr_q),
        .data    (pat_data)
    );

    // Bus controls decode straight from the state register, so reset or a
    // watchdog expiry drops cyc/stb without an extra pipeline stage.
    assign wb_cyc_o       = in_burst;
    assign wb_stb_o       = in_burst;
    assign wb_we_o        = (state == ST_WR_BURST);
    assign wb_sel_o       = in_burst ? '1 : '0;
    assign wb_addr_o      = addr_q;
    assign wb_dat_o       = (state == ST_WR_BURST) ? pat_data : '0;
    assign wb_cti_o       = !in_burst ? 3'b000 : (last_beat ? CTI_EOB : CTI_INCR);
    assign busy           = (state != ST_IDLE) && (state != ST_DONE);
    assign done           = (state == ST_DONE);
    assign pass           = (state == ST_DONE) && (err_q == 16'd0) && !timeout_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_sdrc_wb_traffic_gen.sv
// Self-checking bench for sdrc_wb_traffic_gen (DW=32). A behavioural
// Wishbone slave with a small memory answers the DUT; expected beats are
// queued when a run is launched and a monitor pops them on every ack.
module tb_sdrc_wb_traffic_gen;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [2:0]  cti;
    } beat_t;

    logic        sys_clk = 1'b0;
    logic        RESETN  = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] cfg_base_addr  = '0;
    logic [4:0]  cfg_burst_len  = '0;
    logic [7:0]  cfg_num_bursts = '0;
    logic [1:0]  cfg_mode       = '0;
    logic [31:0] cfg_seed       = '0;
    logic        sdr_init_done  = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
    logic [31:0] wb_addr_o, wb_dat_o, wb_dat_i, first_err_addr;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic        busy, done, pass, timeout;
    logic [15:0] err_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    int ack_wr, ack_rd, cyc_cnt, stall_cnt;
    int stall_idx   = -1;
    int corrupt_idx = -1;
    logic cnt_clr = 1'b0;
    logic gap_chk = 1'b0;
    beat_t exp_q[$];

    always #5 sys_clk = ~sys_clk;

    sdrc_wb_traffic_gen #(.DW(32), .AW(32), .BLW(5), .TO_CYC(1024)) dut (
        .sys_clk        (sys_clk),
        .RESETN         (RESETN),
        .start          (start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_burst_len  (cfg_burst_len),
        .cfg_num_bursts (cfg_num_bursts),
        .cfg_mode       (cfg_mode),
        .cfg_seed       (cfg_seed),
        .sdr_init_done  (sdr_init_done),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_addr_o      (wb_addr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_sel_o       (wb_sel_o),
        .wb_cti_o       (wb_cti_o),
        .wb_ack_i       (wb_ack_i),
        .wb_dat_i       (wb_dat_i),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    // Slave: zero-wait ack unless the selected write beat is stalled; the
    // selected read beat returns data with one bit flipped.
    assign wb_ack_i = wb_cyc_o && wb_stb_o && !(wb_we_o && (ack_wr == stall_idx));
    assign wb_dat_i = mem[wb_addr_o[9:2]] ^ ((!wb_we_o && (ack_rd == corrupt_idx)) ? 32'h0000_0100 : 32'h0);

    always @(posedge sys_clk) begin
        if (cnt_clr) begin
            ack_wr <= 0; ack_rd <= 0; cyc_cnt <= 0; stall_cnt <= 0;
        end else begin
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                if (wb_we_o) begin
                    ack_wr <= ack_wr + 1;
                    mem[wb_addr_o[9:2]] <= wb_dat_o;
                end else begin
                    ack_rd <= ack_rd + 1;
                end
            end
            if (wb_cyc_o) cyc_cnt <= cyc_cnt + 1;
            if (wb_stb_o && !wb_ack_i) stall_cnt <= stall_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: compares every acked beat against the scoreboard and checks
    // that cyc is low in the cycle following an end-of-burst beat.
    always @(negedge sys_clk) begin
        beat_t a, e;
        if (gap_chk) begin
            check("gap_cyc_low", {127'b0, wb_cyc_o}, 128'd0);
            gap_chk = 1'b0;
        end
        if (RESETN && wb_cyc_o && wb_stb_o && wb_ack_i) begin
            a = '{we: wb_we_o, addr: wb_addr_o, data: (wb_we_o ? wb_dat_o : 32'h0),
                  sel: wb_sel_o, cti: wb_cti_o};
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'(a), 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("beat", 128'(a), 128'(e));
            end
            if (wb_cti_o == 3'b111) gap_chk = 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(input logic [1:0] mode, input logic [31:0] seed,
                                             input int n, input logic [31:0] addr);
        logic [31:0] s;
        case (mode)
            2'b00: return seed + 32'(n);
            2'b01: begin
                s = (seed == 32'h0) ? 32'h1 : seed;
                for (int k = 0; k < n; k++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
                return s;
            end
            2'b10: return 32'h1 << (n % 32);
            default: return addr;
        endcase
    endfunction

    task automatic launch(input logic [31:0] base, input logic [4:0] len, input logic [7:0] num,
                          input logic [1:0] mode, input logic [31:0] seed, input int hold);
        int eff;
        beat_t b;
        eff = (len == 5'd0) ? 1 : int'(len);
        if (done) begin
            start = 1'b1; @(negedge sys_clk); start = 1'b0; @(negedge sys_clk);
        end
        exp_q.delete();
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < int'(num) * eff; n++) begin
                b.we   = (ph == 0);
                b.addr = base + 32'(4 * n);
                b.data = (ph == 0) ? exp_data(mode, seed, n, b.addr) : 32'h0;
                b.sel  = 4'hF;
                b.cti  = ((n % eff) == eff - 1) ? 3'b111 : 3'b010;
                exp_q.push_back(b);
            end
        end
        cnt_clr = 1'b1; @(negedge sys_clk); cnt_clr = 1'b0;
        cfg_base_addr = base; cfg_burst_len = len; cfg_num_bursts = num;
        cfg_mode = mode; cfg_seed = seed;
        start = 1'b1;
        repeat (hold) @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && !done; i++) @(negedge sys_clk);
        check(name, {127'b0, done}, 128'd1);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("reset_outputs",
              {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_addr_o, wb_dat_o,
               busy, done, pass, timeout, err_cnt, first_err_addr}, 128'd0);
        RESETN = 1'b1;
        @(negedge sys_clk);

        // Inc pattern, waiting for controller init first.
        launch(32'h100, 5'd8, 8'd4, 2'b00, 32'hA5A5_0000, 1);
        repeat (10) @(negedge sys_clk);
        check("wait_init_busy_no_cyc", {126'b0, busy, wb_cyc_o}, 128'b10);
        sdr_init_done = 1'b1;
        wait_done("inc_done", 300);
        check("inc_status", {pass, timeout, err_cnt, busy}, {1'b1, 1'b0, 16'd0, 1'b0});
        check("inc_beats", 128'({ack_wr[15:0], ack_rd[15:0]}), 128'({16'd32, 16'd32}));
        check("inc_last_word", 128'(mem[8'h5F]), 128'h0000_0000_A5A5_001F);

        // Burst length 1: every beat is end-of-burst with a gap.
        launch(32'h100, 5'd1, 8'd3, 2'b10, 32'h0, 1);
        wait_done("len1_done", 100);
        check("len1_status", {pass, ack_wr[7:0], ack_rd[7:0]}, {1'b1, 8'd3, 8'd3});

        // Burst length 0 behaves as 1; address-as-data pattern.
        launch(32'h140, 5'd0, 8'd2, 2'b11, 32'h0, 1);
        wait_done("len0_done", 100);
        check("len0_status", {pass, ack_wr[7:0], ack_rd[7:0]}, {1'b1, 8'd2, 8'd2});

        // LFSR seed 0 with a corrupted read at beat 5.
        corrupt_idx = 5;
        launch(32'h100, 5'd4, 8'd2, 2'b01, 32'h0, 1);
        wait_done("lfsr_done", 100);
        corrupt_idx = -1;
        check("lfsr_words", {mem[8'h40], mem[8'h41]}, {32'h0000_0001, 32'h8020_0003});
        check("lfsr_err", {pass, err_cnt, first_err_addr}, {1'b0, 16'd1, 32'h0000_0114});

        // Slave stalls write beat 3: watchdog fires after 1024 cycles.
        stall_idx = 3;
        launch(32'h100, 5'd8, 8'd2, 2'b00, 32'h1234_0000, 1);
        wait_done("timeout_done", 1200);
        check("timeout_status", {timeout, pass, wb_cyc_o, wb_stb_o}, 128'b1000);
        check("timeout_stall_cycles", 128'(stall_cnt), 128'd1024);
        stall_idx = -1;
        exp_q.delete();
        gap_chk = 1'b0;

        // Reset mid read burst, then a full clean pass.
        launch(32'h100, 5'd8, 8'd2, 2'b00, 32'h0BAD_0000, 1);
        for (int i = 0; i < 200 && ack_rd < 3; i++) @(negedge sys_clk);
        check("reached_read_phase", {127'b0, (ack_rd >= 3)}, 128'd1);
        #2 RESETN = 1'b0;
        #1 check("async_reset_drop", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, busy, done}, 128'd0);
        exp_q.delete();
        gap_chk = 1'b0;
        @(negedge sys_clk);
        RESETN = 1'b1;
        @(negedge sys_clk);
        launch(32'h100, 5'd8, 8'd2, 2'b00, 32'h0BAD_0000, 1);
        wait_done("after_reset_done", 200);
        check("after_reset_status", {pass, err_cnt, timeout}, {1'b1, 16'd0, 1'b0});

        // Start held high while busy is ignored.
        launch(32'h100, 5'd8, 8'd1, 2'b10, 32'h0, 5);
        wait_done("held_start_done", 100);
        check("held_start_status", {pass, ack_wr[7:0], ack_rd[7:0]}, {1'b1, 8'd8, 8'd8});

        // Zero bursts: finish immediately with no bus activity.
        launch(32'h100, 5'd8, 8'd0, 2'b00, 32'h0, 1);
        check("zero_bursts_done", {done, pass, busy}, 128'b110);
        check("zero_bursts_no_cyc", 128'(cyc_cnt), 128'd0);

        repeat (2) @(negedge sys_clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
